// File: rtl/calc_scheduler.sv
// rtl/calc_scheduler.sv - two-requester round-robin arithmetic scheduler (IDLE/EXEC/RESP)
// Optional divide-by-zero flag output rsp_divz is enabled by defining CALC_DIVZ_FLAG_EN.
module calc_scheduler (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic signed [4:0] r0_a,
  input  logic signed [4:0] r0_b,
  input  logic [1:0]        r0_op,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic signed [4:0] r1_a,
  input  logic signed [4:0] r1_b,
  input  logic [1:0]        r1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic signed [8:0] rsp_result,
  output logic              busy,
  output logic [7:0]        op_count
`ifdef CALC_DIVZ_FLAG_EN
  ,
  output logic              rsp_divz
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic              rr;
  logic              grant;
  logic              accept;
  logic              id_q;
  logic signed [4:0] a_q;
  logic signed [4:0] b_q;
  logic [1:0]        op_q;
  logic signed [8:0] a9;
  logic signed [8:0] b9;
  logic signed [8:0] alu;

  // Single requester wins outright; rr only breaks ties.
  always_comb begin
    grant = rr;
    if (r0_valid && !r1_valid) grant = 1'b0;
    else if (r1_valid && !r0_valid) grant = 1'b1;
  end

  assign r0_ready = (state == IDLE) && r0_valid && !grant;
  assign r1_ready = (state == IDLE) && r1_valid && grant;
  assign accept   = r0_ready || r1_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign a9 = {{4{a_q[4]}}, a_q};
  assign b9 = {{4{b_q[4]}}, b_q};

  // Only -16*-16 reaches 256, which lands on the 9-bit pattern 0x100.
  always_comb begin
    alu = '0;
    case (op_q)
      2'b00: alu = a9 + b9;
      2'b01: alu = a9 - b9;
      2'b10: alu = a9 * b9;
      2'b11: alu = (b_q == 5'sd0) ? 9'sd0 : a9 / b9;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr         <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      op_count   <= '0;
`ifdef CALC_DIVZ_FLAG_EN
      rsp_divz   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        id_q <= grant;
        a_q  <= grant ? r1_a  : r0_a;
        b_q  <= grant ? r1_b  : r0_b;
        op_q <= grant ? r1_op : r0_op;
      end
      if (state == EXEC) begin
        rsp_result <= alu;
        rsp_id     <= id_q;
        rsp_valid  <= 1'b1;
`ifdef CALC_DIVZ_FLAG_EN
        rsp_divz   <= (op_q == 2'b11) && (b_q == 5'sd0);
`endif
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr        <= ~rsp_id;
        op_count  <= op_count + 8'd1;
      end
    end
  end

endmodule
